// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch stage.
//   if_state_e   - fetch FSM state encoding
//   BUBBLE_INSTR - instruction word presented to IF/ID when no instruction is valid
//   PC_INC       - sequential PC increment
package if_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/if_fetch_hold_buf.sv
// if_fetch_hold_buf: one-entry {instr, pc4} register. It parks a fetched word
// that arrived while IF/ID was stalled.
//   clk_i, rst_i     - clock, async active-high reset (clears the entry)
//   i_load           - capture i_instr / i_pc4
//   i_clear          - discard the entry (takes priority over i_load)
//   i_instr, i_pc4   - word to buffer and its pc+4
//   o_instr, o_pc4   - buffered word and its pc+4
module if_fetch_hold_buf
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr <= BUBBLE_INSTR;
      r_pc4   <= 32'h0;
    end else if (i_clear) begin
      r_instr <= BUBBLE_INSTR;
      r_pc4   <= 32'h0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register. It owns the PC
// and keeps a single outstanding request to a variable-latency memory.
//   RESET_PC                 - PC after reset
//   clk_i, rst_i             - clock, async active-high reset
//   pc_write_i               - 0 = hazard stall (IF/ID holds)
//   branch_i/branch_target_i - taken redirect resolved in ID
//   imem_req_o/imem_addr_o   - fetch request, held until imem_ack_i
//   imem_ack_i/imem_rdata_i  - request completion and fetched word
//   pc4_o/instr_o/if_valid_o - presented instruction (bubble = all zero)
//   fetch_stall_o            - waiting on memory
//   if_flush_o               - flush IF/ID (mirrors branch_i)
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        if_valid_o,
  output logic        fetch_stall_o,
  output logic        if_flush_o
);

  if_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  // Address of a request abandoned by a branch; it must be held until its ack.
  logic [31:0] r_drop_addr, w_drop_nxt;
  logic [31:0] w_pc_inc;
  logic        w_buf_load, w_buf_clr;
  logic [31:0] w_buf_instr, w_buf_pc4;
  logic [31:0] w_instr, w_pc4;
  logic        w_valid, w_stall;

  assign w_pc_inc = r_pc + PC_INC;  // wraps modulo 2^32

  if_fetch_hold_buf u_hold_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clr),
    .i_instr (imem_rdata_i),
    .i_pc4   (w_pc_inc),
    .o_instr (w_buf_instr),
    .o_pc4   (w_buf_pc4)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop_addr;
    w_buf_load  = 1'b0;
    w_buf_clr   = 1'b0;
    w_instr     = BUBBLE_INSTR;
    w_pc4       = 32'h0;
    w_valid     = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_stall = !imem_ack_i;
        if (branch_i) begin
          // Wrong-path data is never presented; an unacked request must still
          // be completed at its original address before the target is fetched.
          w_pc_nxt = branch_target_i;
          if (!imem_ack_i) begin
            w_drop_nxt  = r_pc;
            w_state_nxt = ST_DROP;
          end
        end else if (imem_ack_i) begin
          w_pc_nxt = w_pc_inc;
          if (pc_write_i) begin
            w_instr = imem_rdata_i;
            w_pc4   = w_pc_inc;
            w_valid = 1'b1;
          end else begin
            // IF/ID is frozen this cycle, so park the word instead.
            w_buf_load  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (branch_i) begin
          w_buf_clr   = 1'b1;
          w_pc_nxt    = branch_target_i;
          w_state_nxt = ST_FETCH;
        end else begin
          w_instr = w_buf_instr;
          w_pc4   = w_buf_pc4;
          w_valid = 1'b1;
          if (pc_write_i) w_state_nxt = ST_FETCH;
        end
      end
      ST_DROP: begin
        w_stall = 1'b1;
        if (branch_i)   w_pc_nxt    = branch_target_i;
        if (imem_ack_i) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Everything is forced low during reset, including the combinational paths.
  assign imem_req_o    = !rst_i && (r_state == ST_FETCH || r_state == ST_DROP);
  assign imem_addr_o   = rst_i ? 32'h0 : ((r_state == ST_DROP) ? r_drop_addr : r_pc);
  assign instr_o       = rst_i ? BUBBLE_INSTR : w_instr;
  assign pc4_o         = rst_i ? 32'h0 : w_pc4;
  assign if_valid_o    = !rst_i && w_valid;
  assign fetch_stall_o = !rst_i && w_stall;
  assign if_flush_o    = !rst_i && branch_i;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, branch, ack;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr, rdata, pc4, instr;
  logic        valid, stall, flush;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] K = 32'h1357_9BDF;

  always #5 clk = ~clk;

  // Memory returns a recognisable word derived from the address.
  assign rdata = addr ^ K;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pc_write_i      (pc_write),
    .branch_i        (branch),
    .branch_target_i (target),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_rdata_i    (rdata),
    .pc4_o           (pc4),
    .instr_o         (instr),
    .if_valid_o      (valid),
    .fetch_stall_o   (stall),
    .if_flush_o      (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge; outputs are checked at the falling edge.
  task automatic drv(input logic a, input logic pw, input logic br, input logic [31:0] t);
    ack = a; pc_write = pw; branch = br; target = t;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Expect a valid instruction fetched from address a.
  task automatic exp_valid(input string tag, input logic [31:0] a);
    chk({tag, ".req"},   {31'h0, req},   32'd1);
    chk({tag, ".addr"},  addr,           a);
    chk({tag, ".valid"}, {31'h0, valid}, 32'd1);
    chk({tag, ".instr"}, instr,          a ^ K);
    chk({tag, ".pc4"},   pc4,            a + 32'd4);
    chk({tag, ".stall"}, {31'h0, stall}, 32'd0);
  endtask

  task automatic exp_bubble(input string tag, input logic st, input logic fl);
    chk({tag, ".valid"}, {31'h0, valid}, 32'd0);
    chk({tag, ".instr"}, instr,          32'h0);
    chk({tag, ".pc4"},   pc4,            32'h0);
    chk({tag, ".stall"}, {31'h0, stall}, {31'h0, st});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, fl});
  endtask

  initial begin
    rst = 1'b1;
    // Reset: all outputs low even with ack/branch asserted.
    drv(1, 1, 1, 32'h40);
    chk("rst.req",  {31'h0, req}, 32'd0);
    chk("rst.addr", addr, 32'h0);
    exp_bubble("rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // 1: zero-wait memory, one instruction per cycle.
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 0);
      exp_valid($sformatf("seq%0d", i), 32'(i * 4));
      tick();
    end

    // 2: three wait cycles at pc 0xC, then ack.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0);
      chk($sformatf("wait%0d.addr", i), addr, 32'hC);
      exp_bubble($sformatf("wait%0d", i), 1'b1, 1'b0);
      tick();
    end
    drv(1, 1, 0, 0);
    exp_valid("waitack", 32'hC);
    tick();

    // 3: ack at 0x10 while stalled -> bubble, then HOLD for two stalled cycles.
    drv(1, 0, 0, 0);
    exp_bubble("stallack", 1'b0, 1'b0);
    tick();
    drv(0, 0, 0, 0);
    chk("hold0.req",   {31'h0, req},   32'd0);
    chk("hold0.valid", {31'h0, valid}, 32'd1);
    chk("hold0.instr", instr, 32'h10 ^ K);
    chk("hold0.pc4",   pc4,   32'h14);
    tick();
    drv(0, 1, 0, 0);
    chk("hold1.req", {31'h0, req}, 32'd0);
    chk("hold1.pc4", pc4, 32'h14);
    tick();
    drv(1, 1, 0, 0);
    exp_valid("afterhold", 32'h14);
    tick();

    // 4: branch to 0x40 while request to 0x18 is pending -> DROP.
    drv(0, 1, 1, 32'h40);
    chk("br.addr", addr, 32'h18);
    exp_bubble("br", 1'b1, 1'b1);
    tick();
    drv(0, 1, 0, 0);
    chk("drop.req",  {31'h0, req}, 32'd1);
    chk("drop.addr", addr, 32'h18);
    exp_bubble("drop", 1'b1, 1'b0);
    tick();
    drv(1, 1, 0, 0);
    chk("dropack.addr", addr, 32'h18);
    exp_bubble("dropack", 1'b1, 1'b0);
    tick();
    drv(1, 1, 0, 0);
    exp_valid("target", 32'h40);
    tick();

    // 5: branch with ack and stall together -> bubble, no HOLD.
    drv(1, 0, 1, 32'h80);
    exp_bubble("brack", 1'b0, 1'b1);
    tick();
    drv(1, 1, 0, 0);
    exp_valid("brack.tgt", 32'h80);
    tick();

    // Branch out of HOLD to the top of the address space, then wrap.
    drv(1, 0, 0, 0);
    tick();
    drv(0, 0, 1, 32'hFFFF_FFFC);
    chk("brhold.req", {31'h0, req}, 32'd0);
    exp_bubble("brhold", 1'b0, 1'b1);
    tick();
    drv(1, 1, 0, 0);
    chk("wrap.addr",  addr, 32'hFFFF_FFFC);
    chk("wrap.valid", {31'h0, valid}, 32'd1);
    chk("wrap.pc4",   pc4, 32'h0);
    chk("wrap.instr", instr, 32'hFFFF_FFFC ^ K);
    tick();
    drv(1, 1, 0, 0);
    exp_valid("wrap.next", 32'h0);
    tick();

    // 6: reset pulsed mid-request at 0x8.
    drv(1, 1, 0, 0);
    tick();
    drv(0, 1, 0, 0);
    chk("prerst.addr", addr, 32'h8);
    #1 rst = 1'b1;
    #1;
    chk("midrst.req", {31'h0, req}, 32'd0);
    tick();
    rst = 1'b0;
    drv(0, 1, 0, 0);
    chk("postrst.req",  {31'h0, req}, 32'd1);
    chk("postrst.addr", addr, 32'h0);
    tick();
    drv(1, 1, 0, 0);
    exp_valid("postrst", 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
